// File: rtl/grf_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between N_REQ requesters.
// Registered write port, 1 cycle after acceptance; no output back-pressure, requesters wait on req_ready.
module grf_write_arbiter #(
  parameter int N_REQ = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*5-1:0]    req_addr,
  input  logic [N_REQ*32-1:0]   req_data,
  input  logic [N_REQ*32-1:0]   req_pc,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  RegWrite,
  output logic [4:0]            RegAddr,
  output logic [31:0]           RegData,
  output logic [31:0]           PC,
  output logic [2:0]            grant_id,
  output logic [CNT_W-1:0]      conflict_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             reg_write_q, reg_write_d;
  logic [4:0]       reg_addr_q, reg_addr_d;
  logic [31:0]      reg_data_q, reg_data_d;
  logic [31:0]      reg_pc_q, reg_pc_d;
  logic [2:0]       grant_id_q, grant_id_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  logic [N_REQ-1:0] rot_valid;
  logic             gnt_found;
  logic [2:0]       gnt_idx;
  logic [4:0]       sel_addr;
  logic [31:0]      sel_data;
  logic [31:0]      sel_pc;
  int               offset;
  int               pos;
  int               nxt_ptr;

  // Rotate the request vector so the search always starts at bit 0,
  // then map the first hit back to the absolute requester index.
  always_comb begin
    rot_valid = N_REQ'({req_valid, req_valid} >> rr_ptr_q);
    gnt_found = 1'b0;
    offset    = 0;
    pos       = 0;
    gnt_idx   = '0;
    req_ready = '0;
    if (reset && !hold) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (rot_valid[i]) begin
          gnt_found = 1'b1;
          offset    = i;
        end
      end
    end
    pos = int'(rr_ptr_q) + offset;
    if (pos >= N_REQ) begin
      pos = pos - N_REQ;
    end
    if (gnt_found) begin
      gnt_idx = 3'(pos);
      for (int i = 0; i < N_REQ; i++) begin
        if (i == pos) begin
          req_ready[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_pc   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i == int'(gnt_idx)) begin
        sel_addr = req_addr[i*5 +: 5];
        sel_data = req_data[i*32 +: 32];
        sel_pc   = req_pc[i*32 +: 32];
      end
    end
  end

  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    reg_write_d    = 1'b0;
    reg_addr_d     = reg_addr_q;
    reg_data_d     = reg_data_q;
    reg_pc_d       = reg_pc_q;
    grant_id_d     = grant_id_q;
    conflict_cnt_d = conflict_cnt_q;
    nxt_ptr        = int'(gnt_idx) + 1;
    if (nxt_ptr >= N_REQ) begin
      nxt_ptr = 0;
    end
    if (gnt_found) begin
      // A write to $0 is consumed (and advances fairness) but never reaches the file.
      reg_write_d = (sel_addr != 5'd0);
      reg_addr_d  = sel_addr;
      reg_data_d  = sel_data;
      reg_pc_d    = sel_pc;
      grant_id_d  = gnt_idx;
      rr_ptr_d    = PTR_W'(nxt_ptr);
    end
    if (!hold && ($countones(req_valid) > 1) && (conflict_cnt_q != {CNT_W{1'b1}})) begin
      conflict_cnt_d = conflict_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q       <= '0;
      reg_write_q    <= 1'b0;
      reg_addr_q     <= '0;
      reg_data_q     <= '0;
      reg_pc_q       <= '0;
      grant_id_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      reg_write_q    <= reg_write_d;
      reg_addr_q     <= reg_addr_d;
      reg_data_q     <= reg_data_d;
      reg_pc_q       <= reg_pc_d;
      grant_id_q     <= grant_id_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign RegWrite     = reg_write_q;
  assign RegAddr      = reg_addr_q;
  assign RegData      = reg_data_q;
  assign PC           = reg_pc_q;
  assign grant_id     = grant_id_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Randomized + directed bench for grf_write_arbiter against a transaction-level model.
module tb_grf_write_arbiter;
  localparam int N    = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            hold;
  logic [N-1:0]    req_valid;
  logic [N*5-1:0]  req_addr;
  logic [N*32-1:0] req_data;
  logic [N*32-1:0] req_pc;
  logic [N-1:0]    req_ready;
  logic            RegWrite;
  logic [4:0]      RegAddr;
  logic [31:0]     RegData;
  logic [31:0]     PC;
  logic [2:0]      grant_id;
  logic [CW-1:0]   conflict_cnt;

  grf_write_arbiter #(.N_REQ(N), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_pc(req_pc),
    .req_ready(req_ready), .RegWrite(RegWrite), .RegAddr(RegAddr), .RegData(RegData),
    .PC(PC), .grant_id(grant_id), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pending requests held by each requester until accepted.
  bit          pv[N];
  logic [4:0]  pa[N];
  logic [31:0] pd[N];
  logic [31:0] pp[N];

  // Reference model state: what the write port should show right now.
  int          mptr;
  bit          m_we;
  int          m_addr;
  logic [31:0] m_data;
  logic [31:0] m_pc;
  int          m_gid;
  int          m_cnt;
  logic [31:0] rf_m[32];
  logic [31:0] rf_d[32];

  task automatic post(input int i, input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    pv[i] = 1'b1;
    pa[i] = a;
    pd[i] = d;
    pp[i] = p;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = pv[i];
      req_addr[i*5 +: 5]    = pa[i];
      req_data[i*32 +: 32]  = pd[i];
      req_pc[i*32 +: 32]    = pp[i];
    end
  endtask

  // Winner = valid requester with the smallest cyclic distance from the pointer.
  function automatic int pick(input int ptr, input logic [N-1:0] v);
    int best = -1;
    int bd   = N;
    for (int i = 0; i < N; i++) begin
      if (v[i] && ((i - ptr + N) % N) < bd) begin
        bd   = (i - ptr + N) % N;
        best = i;
      end
    end
    return best;
  endfunction

  task automatic cyc(output int g);
    logic [N-1:0] er;
    drive();
    @(negedge clk);
    if (!reset) begin
      mptr = 0; m_we = 0; m_addr = 0; m_data = 0; m_pc = 0; m_gid = 0; m_cnt = 0;
    end
    g  = (reset && !hold) ? pick(mptr, req_valid) : -1;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("RegWrite", RegWrite, m_we);
    chk("RegAddr", RegAddr, m_addr);
    chk("RegData", RegData, m_data);
    chk("PC", PC, m_pc);
    chk("grant_id", grant_id, m_gid);
    chk("conflict_cnt", conflict_cnt, m_cnt);
    if (RegWrite) rf_d[RegAddr] = RegData;
    if (m_we) rf_m[m_addr] = m_data;
    if (reset) begin
      if (!hold && $countones(req_valid) >= 2 && m_cnt < CMAX) m_cnt++;
      if (g >= 0) begin
        m_addr = req_addr[g*5 +: 5];
        m_data = req_data[g*32 +: 32];
        m_pc   = req_pc[g*32 +: 32];
        m_we   = (m_addr != 0);
        m_gid  = g;
        mptr   = (g + 1) % N;
        pv[g]  = 1'b0;
      end else begin
        m_we = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Requesters must keep valid and payload stable until accepted.
  logic [N-1:0]    s_v, s_acc;
  logic [N*5-1:0]  s_a;
  logic [N*32-1:0] s_d, s_p;
  initial begin s_v = '0; s_acc = '0; s_a = '0; s_d = '0; s_p = '0; end
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (s_v[i] && !s_acc[i]) begin
        assert (req_valid[i] && req_addr[i*5 +: 5] == s_a[i*5 +: 5] &&
                req_data[i*32 +: 32] == s_d[i*32 +: 32] && req_pc[i*32 +: 32] == s_p[i*32 +: 32])
          else $error("requester %0d changed its request before acceptance", i);
      end
    end
    s_v   <= req_valid;
    s_acc <= req_valid & req_ready;
    s_a   <= req_addr;
    s_d   <= req_data;
    s_p   <= req_pc;
  end

  initial begin
    int g;
    int gseq[4];
    int cnt0;
    reset = 1'b0;
    hold  = 1'b0;
    for (int i = 0; i < N; i++) post(i, 5'd0, 32'd0, 32'd0);
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    for (int r = 0; r < 32; r++) begin rf_m[r] = '0; rf_d[r] = '0; end
    mptr = 0; m_we = 0; m_addr = 0; m_data = 0; m_pc = 0; m_gid = 0; m_cnt = 0;

    // Reset with both requesters valid
    post(0, 5'd1, 32'h11, 32'h100);
    post(1, 5'd2, 32'h22, 32'h104);
    cyc(g);
    cyc(g);
    chk("rst_ready", req_ready, 2'b00);
    reset = 1'b1;
    cyc(g);
    chk("rst_first_grant", g, 0);
    for (int k = 0; k < 4 && (pv[0] || pv[1]); k++) cyc(g);

    // Single write
    post(0, 5'd5, 32'hDEADBEEF, 32'h00003000);
    cyc(g);
    chk("single_grant", g, 0);
    chk("single_we", RegWrite, 1'b1);
    chk("single_data", RegData, 32'hDEADBEEF);
    chk("single_pc", PC, 32'h00003000);
    cyc(g);
    chk("single_we_drop", RegWrite, 1'b0);

    // $0 write: accepted, dropped, pointer advances to 0
    post(1, 5'd0, 32'd1, 32'h200);
    cyc(g);
    chk("zero_grant", g, 1);
    chk("zero_we", RegWrite, 1'b0);

    // Contention, 4 cycles
    cnt0 = m_cnt;
    for (int k = 0; k < 4; k++) begin
      if (!pv[0]) post(0, 5'd3, 32'h300 + k, 32'h1000 + k);
      if (!pv[1]) post(1, 5'd4, 32'h400 + k, 32'h2000 + k);
      cyc(g);
      gseq[k] = g;
    end
    chk("cont_g0", gseq[0], 0);
    chk("cont_g1", gseq[1], 1);
    chk("cont_g2", gseq[2], 0);
    chk("cont_g3", gseq[3], 1);
    chk("cont_cnt", conflict_cnt, cnt0 + 4);
    for (int k = 0; k < 4 && (pv[0] || pv[1]); k++) cyc(g);

    // Hold for 3 cycles with req0 waiting
    post(0, 5'd6, 32'hCAFEF00D, 32'h4000);
    hold = 1'b1;
    cnt0 = m_cnt;
    for (int k = 0; k < 3; k++) cyc(g);
    chk("hold_we", RegWrite, 1'b0);
    chk("hold_cnt", conflict_cnt, cnt0);
    hold = 1'b0;
    cyc(g);
    chk("hold_release_grant", g, 0);
    chk("hold_release_data", RegData, 32'hCAFEF00D);

    // Bring pointer back to 0, then same-address race
    post(1, 5'd9, 32'h99, 32'h5000);
    cyc(g);
    post(0, 5'd7, 32'd1, 32'h6000);
    post(1, 5'd7, 32'd2, 32'h6004);
    cyc(g);
    chk("race_first", RegData, 32'd1);
    cyc(g);
    chk("race_second", RegData, 32'd2);
    cyc(g);
    chk("race_rf7", rf_d[7], 32'd2);

    // Randomized traffic with a mid-stream reset pulse
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 9) < 6)
          post(i, 5'($urandom_range(0, 7)), $urandom, $urandom);
      end
      hold  = ($urandom_range(0, 6) == 0);
      reset = !(c >= 200 && c < 202);
      cyc(g);
    end
    reset = 1'b1;
    hold  = 1'b0;
    for (int k = 0; k < 6; k++) cyc(g);
    chk("sat_cnt", conflict_cnt, CMAX);
    for (int r = 0; r < 32; r++) chk($sformatf("rf[%0d]", r), rf_d[r], rf_m[r]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
